// File: rtl/game_pkg.sv
// Shared definitions for the game-progression logic: state encoding and
// level width used by the difficulty scheduler and its helpers.
package game_pkg;

   localparam int LEVEL_W       = 4;
   localparam int MAX_LEVEL_DEF = 15;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_OVER      = 3'd4
   } game_state_t;

   typedef logic [LEVEL_W-1:0] level_t;

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and emits a
// single-cycle sec_tick on the terminal count. clr forces the count to 0.
module sec_prescaler #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic sec_tick
);

   localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [CNT_W-1:0] cnt;

   assign sec_tick = en && (cnt == CNT_W'(CLK_HZ - 1));

   // Count while enabled, wrap on the terminal count, clear on request.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         if (sec_tick) cnt <= '0;
         else          cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/difficulty_scheduler.sv
// Game-progression controller: sequences IDLE/COUNTDOWN/PLAY/PAUSE/OVER,
// tracks hit/miss streaks into a pending level, and commits the pending
// level to the divider only on a fall_tick so a step never changes period.
module difficulty_scheduler
   import game_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int COUNTDOWN_S    = 3,
   parameter int HITS_PER_LEVEL = 8,
   parameter int MISS_LIMIT     = 3,
   parameter int START_LEVEL    = 0,
   parameter int MAX_LEVEL      = MAX_LEVEL_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pause_toggle,
   input  logic               end_game,
   input  logic               hit,
   input  logic               miss,
   input  logic               fall_tick,
   output logic [LEVEL_W-1:0] difficulty,
   output logic [2:0]         game_state,
   output logic [1:0]         countdown,
   output logic               run_en,
   output logic               level_up,
   output logic               level_down
);

   localparam int HIT_W  = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
   localparam int MISS_W = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;

   game_state_t       state, state_d;
   logic [1:0]        countdown_d;
   logic [HIT_W-1:0]  hit_cnt, hit_cnt_d;
   logic [MISS_W-1:0] miss_cnt, miss_cnt_d;
   level_t            pending, pending_d;
   level_t            difficulty_d;
   logic              run_en_d, level_up_d, level_down_d;
   logic              sec_tick;

   // The prescaler only runs in COUNTDOWN and sits at 0 everywhere else,
   // so every entry into COUNTDOWN starts a full second.
   sec_prescaler #(.CLK_HZ(CLK_HZ)) u_sec_prescaler (
      .clk      (clk),
      .rst      (rst),
      .clr      (state != ST_COUNTDOWN),
      .en       (state == ST_COUNTDOWN),
      .sec_tick (sec_tick)
   );

   // Next-state, counter, pending-level and commit logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      state_d      = state;
      countdown_d  = countdown;
      hit_cnt_d    = hit_cnt;
      miss_cnt_d   = miss_cnt;
      pending_d    = pending;
      difficulty_d = difficulty;
      run_en_d     = run_en;
      level_up_d   = 1'b0;
      level_down_d = 1'b0;

      unique case (state)
         ST_IDLE, ST_OVER: begin
            run_en_d = 1'b0;
            if (start) begin
               state_d      = ST_COUNTDOWN;
               countdown_d  = 2'(COUNTDOWN_S);
               hit_cnt_d    = '0;
               miss_cnt_d   = '0;
               pending_d    = level_t'(START_LEVEL);
               difficulty_d = level_t'(START_LEVEL);
            end
         end

         ST_COUNTDOWN: begin
            if (end_game) begin
               state_d  = ST_OVER;
               run_en_d = 1'b0;
            end else if (sec_tick) begin
               if (countdown == 2'd1) begin
                  countdown_d = 2'd0;
                  state_d     = ST_PLAY;
                  run_en_d    = 1'b1;
               end else begin
                  countdown_d = countdown - 2'd1;
               end
            end
         end

         ST_PLAY: begin
            // Commit uses the registered pending value, so an update made in
            // this same cycle waits for the next fall_tick.
            if (fall_tick) begin
               difficulty_d = pending;
               level_up_d   = (pending > difficulty);
               level_down_d = (pending < difficulty);
            end

            if (end_game) begin
               state_d  = ST_OVER;
               run_en_d = 1'b0;
            end else if (pause_toggle) begin
               state_d  = ST_PAUSE;
               run_en_d = 1'b0;
            end else if (hit) begin
               miss_cnt_d = '0;
               if (hit_cnt == HIT_W'(HITS_PER_LEVEL - 1)) begin
                  hit_cnt_d = '0;
                  if (pending < level_t'(MAX_LEVEL)) pending_d = pending + 1'b1;
               end else begin
                  hit_cnt_d = hit_cnt + 1'b1;
               end
            end else if (miss) begin
               if (miss_cnt == MISS_W'(MISS_LIMIT - 1)) begin
                  miss_cnt_d = '0;
                  if (pending != '0) pending_d = pending - 1'b1;
               end else begin
                  miss_cnt_d = miss_cnt + 1'b1;
               end
            end
         end

         ST_PAUSE: begin
            if (end_game) begin
               state_d  = ST_OVER;
               run_en_d = 1'b0;
            end else if (pause_toggle) begin
               state_d  = ST_PLAY;
               run_en_d = 1'b1;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            run_en_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset overrides every input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         countdown  <= 2'd0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         pending    <= level_t'(START_LEVEL);
         difficulty <= level_t'(START_LEVEL);
         run_en     <= 1'b0;
         level_up   <= 1'b0;
         level_down <= 1'b0;
      end else begin
         state      <= state_d;
         countdown  <= countdown_d;
         hit_cnt    <= hit_cnt_d;
         miss_cnt   <= miss_cnt_d;
         pending    <= pending_d;
         difficulty <= difficulty_d;
         run_en     <= run_en_d;
         level_up   <= level_up_d;
         level_down <= level_down_d;
      end
   end

   assign game_state = state;

endmodule
